// File: rtl/tdc_reader_pkg.sv
// -----------------------------------------------------------------------------
// tdc_reader_pkg
// Shared types and constants for the ring-oscillator TDC sample reader.
//   state_e    : reader FSM states (IDLE, SETTLE, SAMPLE, DONE)
//   TDC_CNT_W  : width of the tile's time count (uo_out)
//   TDC_SEL_W  : width of the tile's oscillator mux select (ui_in[1:0])
// Optional feature macro used by the reader: TDC_READER_MINMAX_EN.
// -----------------------------------------------------------------------------
package tdc_reader_pkg;

    localparam int TDC_CNT_W = 8;
    localparam int TDC_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tdc_count_sync.sv
// -----------------------------------------------------------------------------
// tdc_count_sync
// Brings the tile's free-running time count into the clk domain through a
// two-flop synchronizer and keeps the previous synchronized value so the
// reader can tell whether the count held still for a cycle.
// Ports:
//   clk        in  : system clock
//   rst_n      in  : asynchronous active-low reset (all flops cleared)
//   tile_count in  : TDC tile uo_out, asynchronous to clk
//   cnt_s      out : synchronized count
//   stable     out : cnt_s equals its value one cycle earlier
// -----------------------------------------------------------------------------
module tdc_count_sync
    import tdc_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TDC_CNT_W-1:0] tile_count,
    output logic [TDC_CNT_W-1:0] cnt_s,
    output logic                 stable
);

    logic [TDC_CNT_W-1:0] sync1_q;
    logic [TDC_CNT_W-1:0] sync2_q;
    logic [TDC_CNT_W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= tile_count;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign cnt_s  = sync2_q;
    // A multi-bit count sampled mid-transition can be incoherent; two equal
    // consecutive values mean the count was not moving across the capture.
    assign stable = (sync2_q == prev_q);

endmodule

// File: rtl/tdc_sample_reader.sv
// -----------------------------------------------------------------------------
// tdc_sample_reader
// Host-side reader for the ring-oscillator TDC tile. On start it selects the
// oscillator, waits SETTLE_CYCLES clocks, sums 2^SAMPLES_LOG2 stable count
// samples and offers the raw sum on a ready/valid port.
// Parameters:
//   SAMPLES_LOG2  : log2 of samples per measurement (0..8)
//   SETTLE_CYCLES : clocks spent in SETTLE after a select change (1..255)
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, sel_req     : measurement request (IDLE only) and oscillator select
//   tile_sel           : to tile ui_in[1:0], held in IDLE
//   tile_count         : from tile uo_out (asynchronous)
//   res_data/res_valid/res_ready : result sum and handshake
//   res_min, res_max   : min/max accepted sample (only with TDC_READER_MINMAX_EN)
//   busy               : high whenever the FSM is not in IDLE
// Optional feature macro: TDC_READER_MINMAX_EN.
// -----------------------------------------------------------------------------
module tdc_sample_reader
    import tdc_reader_pkg::*;
#(
    parameter int SAMPLES_LOG2  = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [TDC_SEL_W-1:0]           sel_req,
    output logic [TDC_SEL_W-1:0]           tile_sel,
    input  logic [TDC_CNT_W-1:0]           tile_count,
    output logic [TDC_CNT_W+SAMPLES_LOG2-1:0] res_data,
    output logic                           res_valid,
    input  logic                           res_ready,
`ifdef TDC_READER_MINMAX_EN
    output logic [TDC_CNT_W-1:0]           res_min,
    output logic [TDC_CNT_W-1:0]           res_max,
`endif
    output logic                           busy
);

    localparam int ACC_W = TDC_CNT_W + SAMPLES_LOG2;
    // One spare bit so the counter works for SAMPLES_LOG2 = 0 as well.
    localparam int CNT_W = SAMPLES_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << SAMPLES_LOG2) - 1);
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);

    logic [TDC_CNT_W-1:0] cnt_s;
    logic                 stable;

    tdc_count_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .tile_count (tile_count),
        .cnt_s      (cnt_s),
        .stable     (stable)
    );

    state_e               state_q,  state_d;
    logic [TDC_SEL_W-1:0] sel_q,    sel_d;
    logic [ACC_W-1:0]     acc_q,    acc_d;
    logic [CNT_W-1:0]     scnt_q,   scnt_d;
    logic [7:0]           settle_q, settle_d;
`ifdef TDC_READER_MINMAX_EN
    logic [TDC_CNT_W-1:0] min_q,    min_d;
    logic [TDC_CNT_W-1:0] max_q,    max_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            acc_q    <= '0;
            scnt_q   <= '0;
            settle_q <= '0;
`ifdef TDC_READER_MINMAX_EN
            min_q    <= '0;
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            scnt_q   <= scnt_d;
            settle_q <= settle_d;
`ifdef TDC_READER_MINMAX_EN
            min_q    <= min_d;
            max_q    <= max_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        scnt_d   = scnt_q;
        settle_d = settle_q;
`ifdef TDC_READER_MINMAX_EN
        min_d    = min_q;
        max_d    = max_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d    = sel_req;
                    acc_d    = '0;
                    scnt_d   = '0;
                    settle_d = SETTLE_INIT;
`ifdef TDC_READER_MINMAX_EN
                    min_d    = '0;
                    max_d    = '0;
`endif
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                // Leaving on the cycle the counter reads 1 gives exactly
                // SETTLE_CYCLES cycles in this state.
                if (settle_q == 8'd1) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            SAMPLE: begin
                if (stable) begin
                    acc_d  = acc_q + ACC_W'(cnt_s);
                    scnt_d = scnt_q + CNT_W'(1);
`ifdef TDC_READER_MINMAX_EN
                    if (scnt_q == '0) begin
                        min_d = cnt_s;
                        max_d = cnt_s;
                    end else begin
                        if (cnt_s < min_q) min_d = cnt_s;
                        if (cnt_s > max_q) max_d = cnt_s;
                    end
`endif
                    if (scnt_q == LAST_SAMPLE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The accumulator only moves on start or in SAMPLE, so the result is
    // frozen for the whole of DONE.
    assign res_data  = acc_q;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign tile_sel  = sel_q;
`ifdef TDC_READER_MINMAX_EN
    assign res_min   = min_q;
    assign res_max   = max_q;
`endif

endmodule

// File: tb/tb_tdc_sample_reader.sv
// -----------------------------------------------------------------------------
// tb_tdc_sample_reader
// Directed bench for tdc_sample_reader. Two instances: u_dut4 (SAMPLES_LOG2=4)
// for most scenarios and u_dut8 (SAMPLES_LOG2=8) for the full-scale sum.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Min/max scenario is built only with TDC_READER_MINMAX_EN.
// -----------------------------------------------------------------------------
module tb_tdc_sample_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic [1:0]  sel_req = 2'd0;
    logic [7:0]  tile_count = 8'd0;
    logic        res_ready = 1'b0;

    logic [1:0]  tile_sel, tile_sel8;
    logic [11:0] res_data;
    logic [15:0] res_data8;
    logic        res_valid, res_valid8;
    logic        busy, busy8;
`ifdef TDC_READER_MINMAX_EN
    logic [7:0]  res_min, res_max, res_min8, res_max8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdc_sample_reader #(.SAMPLES_LOG2(4), .SETTLE_CYCLES(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel_req    (sel_req),
        .tile_sel   (tile_sel),
        .tile_count (tile_count),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
`ifdef TDC_READER_MINMAX_EN
        .res_min    (res_min),
        .res_max    (res_max),
`endif
        .busy       (busy)
    );

    tdc_sample_reader #(.SAMPLES_LOG2(8), .SETTLE_CYCLES(4)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .sel_req    (sel_req),
        .tile_sel   (tile_sel8),
        .tile_count (tile_count),
        .res_data   (res_data8),
        .res_valid  (res_valid8),
        .res_ready  (res_ready),
`ifdef TDC_READER_MINMAX_EN
        .res_min    (res_min8),
        .res_max    (res_max8),
`endif
        .busy       (busy8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 edge after start was sampled; lat = edges counted from the
    // start-sampling edge until res_valid is seen, or -1 on timeout.
    task automatic wait_valid(input bit use8, output int lat);
        lat = -1;
        for (int k = 1; k <= 600; k++) begin
            if (use8 ? res_valid8 : res_valid) begin
                lat = k;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (tile_sel !== 2'd0)   begin n_fail++; $display("FAIL reset_tile_sel: got %0d want 0", tile_sel); end
        n_checks++; if (res_data !== 12'd0)  begin n_fail++; $display("FAIL reset_res_data: got %0d want 0", res_data); end
        n_checks++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (busy8 !== 1'b0)      begin n_fail++; $display("FAIL reset_busy8: got %b want 0", busy8); end
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_constant();
        int lat;
        tile_count = 8'd100;
        res_ready  = 1'b1;
        repeat (4) step();
        sel_req = 2'd2;
        start   = 1'b1;
        step();
        start   = 1'b0;
        sel_req = 2'd0;
        n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL const_busy: got %b want 1", busy); end
        n_checks++; if (tile_sel !== 2'd2)   begin n_fail++; $display("FAIL const_tile_sel: got %0d want 2", tile_sel); end
        n_checks++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL const_early_valid: got %b want 0", res_valid); end
        wait_valid(1'b0, lat);
        n_checks++; if (lat != 21)           begin n_fail++; $display("FAIL const_latency: got %0d want 21", lat); end
        n_checks++; if (res_data !== 12'd1600) begin n_fail++; $display("FAIL const_res_data: got %0d want 1600", res_data); end
        step();
        n_checks++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL const_done_1cycle: got %b want 0", res_valid); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL const_idle_busy: got %b want 0", busy); end
        n_checks++; if (tile_sel !== 2'd2)   begin n_fail++; $display("FAIL const_sel_hold: got %0d want 2", tile_sel); end
        $display("test_constant done: latency %0d sum %0d", lat, res_data);
    endtask

    // Start in the first IDLE cycle after the handshake.
    task automatic test_back_to_back();
        int lat;
        tile_count = 8'd30;
        sel_req = 2'd1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
        n_checks++; if (tile_sel !== 2'd1)   begin n_fail++; $display("FAIL b2b_tile_sel: got %0d want 1", tile_sel); end
        wait_valid(1'b0, lat);
        n_checks++; if (lat != 21)           begin n_fail++; $display("FAIL b2b_latency: got %0d want 21", lat); end
        n_checks++; if (res_data !== 12'd480) begin n_fail++; $display("FAIL b2b_res_data: got %0d want 480", res_data); end
        step();
        $display("test_back_to_back done: latency %0d sum %0d", lat, res_data);
    endtask

    task automatic test_max();
        int lat;
        tile_count = 8'hFF;
        res_ready  = 1'b1;
        repeat (4) step();
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n_checks++; if (busy8 !== 1'b1)      begin n_fail++; $display("FAIL max_busy: got %b want 1", busy8); end
        wait_valid(1'b1, lat);
        n_checks++; if (lat != 261)          begin n_fail++; $display("FAIL max_latency: got %0d want 261", lat); end
        n_checks++; if (res_data8 !== 16'hFF00) begin n_fail++; $display("FAIL max_res_data: got %h want ff00", res_data8); end
        step();
        n_checks++; if (res_valid8 !== 1'b0) begin n_fail++; $display("FAIL max_handshake: got %b want 0", res_valid8); end
        $display("test_max done: latency %0d sum %h", lat, res_data8);
    endtask

    // Count toggles for 10 drive cycles early in SAMPLE; 11 sampled cycles
    // are unstable, so the 16th stable 7 lands 11 cycles late.
    task automatic test_unstable();
        int lat;
        res_ready  = 1'b0;
        tile_count = 8'd7;
        repeat (4) step();
        sel_req = 2'd3;
        start   = 1'b1;
        step();
        start   = 1'b0;
        lat = -1;
        for (int e = 0; e < 200; e++) begin
            if (e > 0) step();
            if (e >= 4 && e <= 13) tile_count = (e % 2 == 0) ? 8'h55 : 8'hAA;
            else                   tile_count = 8'd7;
            if (res_valid) begin
                lat = e + 1;
                break;
            end
        end
        n_checks++; if (lat != 32)           begin n_fail++; $display("FAIL unstable_latency: got %0d want 32", lat); end
        n_checks++; if (res_data !== 12'd112) begin n_fail++; $display("FAIL unstable_res_data: got %0d want 112", res_data); end
        n_checks++; if (tile_sel !== 2'd3)   begin n_fail++; $display("FAIL unstable_tile_sel: got %0d want 3", tile_sel); end
        $display("test_unstable done: latency %0d sum %0d", lat, res_data);
    endtask

    // Continues from test_unstable with the result still pending.
    task automatic test_backpressure();
        sel_req = 2'd1;
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (res_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, res_valid); end
            n_checks++; if (res_data !== 12'd112) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d want 112", i, res_data); end
            start = (i % 3 == 0);
            tile_count = 8'(i * 13);
            step();
        end
        start = 1'b0;
        n_checks++; if (tile_sel !== 2'd3)   begin n_fail++; $display("FAIL bp_sel_ignored: got %0d want 3", tile_sel); end
        res_ready = 1'b1;
        step();
        n_checks++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", res_valid); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL bp_release_busy: got %b want 0", busy); end
        step();
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL bp_no_queue: got %b want 0", busy); end
        $display("test_backpressure done");
    endtask

    task automatic test_midreset();
        int lat;
        tile_count = 8'd100;
        res_ready  = 1'b1;
        repeat (4) step();
        sel_req = 2'd2;
        start   = 1'b1;
        step();
        start   = 1'b0;
        repeat (10) step();
        n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL mrst_pre_busy: got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (tile_sel !== 2'd0)   begin n_fail++; $display("FAIL mrst_tile_sel: got %0d want 0", tile_sel); end
        n_checks++; if (res_data !== 12'd0)  begin n_fail++; $display("FAIL mrst_res_data: got %0d want 0", res_data); end
        n_checks++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL mrst_res_valid: got %b want 0", res_valid); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL mrst_busy: got %b want 0", busy); end
        tile_count = 8'd50;
        step();
        rst_n   = 1'b1;
        sel_req = 2'd1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        wait_valid(1'b0, lat);
        n_checks++; if (lat != 21)           begin n_fail++; $display("FAIL mrst_latency: got %0d want 21", lat); end
        n_checks++; if (res_data !== 12'd800) begin n_fail++; $display("FAIL mrst_res_data: got %0d want 800", res_data); end
        n_checks++; if (tile_sel !== 2'd1)   begin n_fail++; $display("FAIL mrst_tile_sel_new: got %0d want 1", tile_sel); end
        step();
        $display("test_midreset done: latency %0d sum %0d", lat, res_data);
    endtask

`ifdef TDC_READER_MINMAX_EN
    task automatic test_minmax();
        int lat;
        res_ready  = 1'b1;
        tile_count = 8'd10;
        repeat (4) step();
        sel_req = 2'd0;
        start   = 1'b1;
        step();
        start   = 1'b0;
        lat = -1;
        for (int e = 0; e < 200; e++) begin
            if (e > 0) step();
            tile_count = ((e / 2) % 2 == 0) ? 8'd10 : 8'd50;
            if (res_valid) begin
                lat = e + 1;
                break;
            end
        end
        n_checks++; if (lat <= 21)           begin n_fail++; $display("FAIL minmax_latency: got %0d want >21", lat); end
        n_checks++; if (res_min !== 8'd10)   begin n_fail++; $display("FAIL minmax_min: got %0d want 10", res_min); end
        n_checks++; if (res_max !== 8'd50)   begin n_fail++; $display("FAIL minmax_max: got %0d want 50", res_max); end
        step();
        $display("test_minmax done: min %0d max %0d", res_min, res_max);
    endtask
`endif

    initial begin
        test_reset();
        test_constant();
        test_back_to_back();
        test_max();
        test_unstable();
        test_backpressure();
        test_midreset();
`ifdef TDC_READER_MINMAX_EN
        test_minmax();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_sample_reader.md
# tdc_sample_reader

Host-side reader for the ring-oscillator TDC tile. Drives the tile's 2-bit oscillator mux select, waits for the tile's 8-bit time count to settle, captures a programmable number of stable samples and sums them. It delivers the accumulated result on a ready/valid output toward the host/scan logic. It sits between the TDC tile's `ui_in[1:0]`/`uo_out[7:0]` and the measurement controller.

## Interface
- `SAMPLES_LOG2`, default 4: log2 of the sample count per measurement; range 0..8.
- `SETTLE_CYCLES`, default 4: clocks to wait after a select change before the first sample; range 1..255.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `sel_req` in 2: oscillator select for the measurement; latched when `start` is accepted.
- `tile_sel` out 2: drives TDC tile `ui_in[1:0]`.
- `tile_count` in 8: TDC tile `uo_out`; asynchronous to `clk`.
- `res_data` out 8+SAMPLES_LOG2: sum of accepted samples.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `tile_count` passes through a 2-flop synchronizer, giving `cnt_s`. A sample is stable when `cnt_s` equals its value one cycle earlier.
- FSM states:
  - IDLE: `busy`=0. On `start`, latch `sel_req` into `tile_sel`, clear the accumulator and sample counter, load the settle counter with SETTLE_CYCLES, then go to SETTLE.
  - SETTLE: decrement the settle counter. When it reaches 1, go to SAMPLE.
  - SAMPLE: on each cycle with a stable sample, add `cnt_s` zero-extended to the accumulator and increment the sample counter. Unstable cycles are skipped and not counted. After the 2^SAMPLES_LOG2-th accepted sample, go to DONE.
  - DONE: `res_valid`=1 and `res_data` holds the sum. When `res_valid && res_ready`, go to IDLE.
- Arithmetic: the accumulator is 8+SAMPLES_LOG2 bits wide and cannot overflow (max 255·2^N). `res_data` is the raw sum; the consumer shifts it to get the mean.
- `tile_sel` keeps its last value in IDLE, so the oscillator is not reselected needlessly.
- `start` outside IDLE is ignored; no queueing.
- `res_data` is stable and unchanged while `res_valid`=1.
- Reset at any time returns the block to IDLE. Reset values: `tile_sel`=0, `res_data`=0, `res_valid`=0, `busy`=0, synchronizer flops=0.

## Timing
- `start` sampled at edge T: `busy`=1 and `tile_sel` updated from T+1.
- SETTLE occupies SETTLE_CYCLES cycles.
- SAMPLE lasts at least 2^SAMPLES_LOG2 cycles, more if unstable cycles are skipped.
- `res_valid` rises the cycle after the last accepted sample.
- Handshake completes on the edge where `res_valid && res_ready`. IDLE and `busy`=0 follow on the next cycle. The earliest new `start` is accepted on the cycle after that.
- Minimum latency from `start` to `res_valid`, with a constant input: 1 + SETTLE_CYCLES + 2^SAMPLES_LOG2 cycles.
- `res_ready` held high in advance: DONE lasts exactly 1 cycle.

## Configuration
- `TDC_READER_MINMAX_EN` defined: adds outputs `res_min` (8) and `res_max` (8), holding the minimum and maximum accepted samples of the measurement.
  - Both are updated in SAMPLE alongside the accumulator.
  - Both are initialised at the first accepted sample.
  - Both follow the same reset and hold rules as `res_data`.
- Not defined: these ports and their registers do not exist. All other behaviour is identical.

## Structure
- Package `tdc_reader_pkg`: FSM state enum (IDLE, SETTLE, SAMPLE, DONE), `TDC_CNT_W`=8, `TDC_SEL_W`=2.
- Sub-module `tdc_count_sync`: 2-flop synchronizer plus previous-value register, producing `cnt_s` and `stable`. Everything else lives in the top level.

## Test plan
- Constant count: `tile_count`=8'd100, SAMPLES_LOG2=4, `start` with `sel_req`=2 -> `tile_sel`=2, `res_data`=1600, `res_valid` exactly 1+4+16 cycles after `start`.
- Max value: `tile_count`=8'hFF, SAMPLES_LOG2=8 -> `res_data`=65280 (16'hFF00), no overflow.
- Unstable input: `tile_count` toggles every cycle for 10 cycles, then holds 8'd7 -> toggling cycles are not counted, `res_data`=112.
- Backpressure: `res_ready`=0 for 20 cycles in DONE -> `res_valid` and `res_data` held constant; `start` pulses during DONE are ignored.
- Mid-operation reset: assert `rst_n`=0 during SAMPLE -> all outputs return to reset values immediately. A new `start` afterwards gives a correct fresh sum.
- With `TDC_READER_MINMAX_EN`: samples alternate 8'd10 and 8'd50 at a 2-cycle hold -> `res_min`=10, `res_max`=50.
